// File: rtl/vic_sound_mc.sv
// vic_sound_mc: NUM_TONE octave-spaced square voices plus one LFSR noise voice,
// CPU register file, and popcount x amplitude mixer.
// Ports: clk/reset (sync, active high); i_ena base tick; i_we/i_addr/i_wdata
// register writes; o_rdata combinational read-back; o_chan raw voice bits
// (MSB = noise); o_audio registered mix, one clk behind o_chan.
module vic_sound_mc #(
  parameter int          NUM_TONE  = 3,
  parameter int          PRE_MIN   = 4,
  parameter int          ADDR_W    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          OUT_W     = $clog2(NUM_TONE+2)+4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_ena,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [7:0]          i_wdata,
  output logic [7:0]          o_rdata,
  output logic [NUM_TONE:0]   o_chan,
  output logic [OUT_W-1:0]    o_audio
);

  localparam int NV       = NUM_TONE + 1;        // tone voices + noise voice
  localparam int PW       = PRE_MIN + NUM_TONE;  // prescaler width
  localparam int AMP_ADDR = NUM_TONE + 1;
  localparam int CW       = $clog2(NUM_TONE+2);  // popcount width

  // Prescale exponent per voice; the noise voice shares voice 0's rate.
  function automatic int pre_exp(input int k);
    if (k >= NUM_TONE) return PRE_MIN + NUM_TONE - 1;
    return PRE_MIN + (NUM_TONE - 1 - k);
  endfunction

  // Low-order ones mask of width p.
  function automatic logic [PW-1:0] tick_mask(input int p);
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < PW; i++) begin
      if (i < p) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [7:0]       reg_q [NV];
  logic [7:0]       reg_d [NV];
  logic [3:0]       amp_q, amp_d;
  logic [6:0]       cnt_q [NV];
  logic [6:0]       cnt_d [NV];
  logic [NV-1:0]    chan_q, chan_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [OUT_W-1:0] audio_q, audio_d;
  logic [NV-1:0]    tick;
  logic [CW-1:0]    pop;

  always_comb begin
    for (int k = 0; k < NV; k++) begin
      tick[k] = i_ena && ((pre_q & tick_mask(pre_exp(k))) == tick_mask(pre_exp(k)));
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NV; k++) pop = pop + CW'(chan_q[k]);
  end

  always_comb begin
    reg_d   = reg_q;
    amp_d   = amp_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    lfsr_d  = lfsr_q;
    pre_d   = i_ena ? pre_q + PW'(1) : pre_q;
    audio_d = OUT_W'(pop) * OUT_W'(amp_q);

    if (i_we) begin
      for (int k = 0; k < NV; k++) begin
        if (i_addr == ADDR_W'(k)) reg_d[k] = i_wdata;
      end
      if (i_addr == ADDR_W'(AMP_ADDR)) amp_d = i_wdata[3:0];
    end

    for (int k = 0; k < NV; k++) begin
      // Disabled before or after this cycle's write: park cnt at the
      // incoming F so a re-enable counts a full 128-F ticks, and a
      // disable landing on a wrap still forces the bit low.
      if (!reg_q[k][7] || !reg_d[k][7]) begin
        cnt_d[k]  = reg_d[k][6:0];
        chan_d[k] = 1'b0;
      end else if (tick[k]) begin
        if (cnt_q[k] == 7'h7F) begin
          cnt_d[k] = reg_q[k][6:0];
          if (k == NUM_TONE) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            chan_d[k] = lfsr_d[0];
          end else begin
            chan_d[k] = ~chan_q[k];
          end
        end else begin
          cnt_d[k] = cnt_q[k] + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NV; k++) begin
        reg_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      amp_q   <= '0;
      chan_q  <= '0;
      pre_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      audio_q <= '0;
    end else begin
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      chan_q  <= chan_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      audio_q <= audio_d;
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    for (int k = 0; k < NV; k++) begin
      if (i_addr == ADDR_W'(k)) o_rdata = reg_q[k];
    end
    if (i_addr == ADDR_W'(AMP_ADDR)) o_rdata = {4'h0, amp_q};
  end

  assign o_chan  = chan_q;
  assign o_audio = audio_q;

endmodule

// File: tb/tb_vic_sound_mc.sv
// Testbench for vic_sound_mc (NUM_TONE=3, PRE_MIN=0): directed scenarios then
// randomized traffic, each cycle compared against a countdown-based model.
module tb_vic_sound_mc;
  localparam int NT = 3;
  localparam int NV = NT + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_ena;
  logic       i_we;
  logic [2:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;
  logic [3:0] o_chan;
  logic [6:0] o_audio;

  always #5 clk = ~clk;

  vic_sound_mc #(
    .NUM_TONE (NT),
    .PRE_MIN  (0),
    .ADDR_W   (3),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_ena  (i_ena),
    .i_we   (i_we),
    .i_addr (i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_chan (o_chan),
    .o_audio(o_audio)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: each voice tracks ticks remaining until its next edge.
  int m_reg [NV];
  int m_amp;
  int m_rem [NV];
  int m_bit [NV];
  int m_lfsr;
  int m_audio;
  int m_ena_cnt;

  task automatic m_reset();
    for (int k = 0; k < NV; k++) begin
      m_reg[k] = 0;
      m_rem[k] = 128;
      m_bit[k] = 0;
    end
    m_amp = 0; m_lfsr = 16'hACE1; m_audio = 0; m_ena_cnt = 0;
  endtask

  function automatic int exp_rdata(input int addr);
    if (addr < NV) return m_reg[addr];
    if (addr == NV) return m_amp;
    return 0;
  endfunction

  task automatic m_step(input bit rst, input bit ena, input bit we, input int addr, input int wdata);
    int nreg [NV];
    int namp, pop, p, lsb;
    bit tk;
    if (rst) begin
      m_reset();
      return;
    end
    nreg = m_reg;
    namp = m_amp;
    if (we) begin
      if (addr < NV) nreg[addr] = wdata;
      else if (addr == NV) namp = wdata % 16;
    end
    pop = 0;
    for (int k = 0; k < NV; k++) pop += m_bit[k];
    m_audio = pop * m_amp;
    for (int k = 0; k < NV; k++) begin
      p  = (k < NT) ? (NT - 1 - k) : (NT - 1);
      tk = ena && (((m_ena_cnt + 1) % (1 << p)) == 0);
      if (m_reg[k] < 128 || nreg[k] < 128) begin
        m_rem[k] = 128 - (nreg[k] % 128);
        m_bit[k] = 0;
      end else if (tk) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_rem[k] = 128 - (m_reg[k] % 128);
          if (k < NT) m_bit[k] = 1 - m_bit[k];
          else begin
            lsb = m_lfsr % 2;
            m_lfsr = m_lfsr / 2;
            if (lsb == 1) m_lfsr = m_lfsr ^ 16'hB400;
            m_bit[k] = m_lfsr % 2;
          end
        end
      end
    end
    if (ena) m_ena_cnt++;
    m_reg = nreg;
    m_amp = namp;
  endtask

  task automatic cyc(input bit rst, input bit ena, input bit we, input int addr, input int wdata);
    logic [3:0] ec;
    @(negedge clk);
    reset = rst; i_ena = ena; i_we = we; i_addr = addr[2:0]; i_wdata = wdata[7:0];
    #1;
    check("rdata", {24'h0, o_rdata}, exp_rdata(addr));
    m_step(rst, ena, we, addr, wdata);
    @(posedge clk);
    #1;
    for (int k = 0; k < NV; k++) ec[k] = (m_bit[k] != 0);
    check("chan", {28'h0, o_chan}, {28'h0, ec});
    check("audio", {25'h0, o_audio}, m_audio);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, $urandom_range(0, 7), 0);
  endtask

  initial begin
    int wd;
    reset = 1'b1; i_ena = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    @(posedge clk);
    #1;
    m_reset();
    cyc(1'b1, 1'b1, 1'b0, 0, 0);

    // Reset state: every address reads zero
    for (int a = 0; a < 8; a++) cyc(1'b0, 1'b0, 1'b0, a, 0);

    // Amplitude upper bits not stored; fast voice 2 at F=126
    cyc(1'b0, 1'b1, 1'b1, 4, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 4, 8'h0F);
    cyc(1'b0, 1'b1, 1'b1, 2, 8'hFE);
    run(12);

    // Voices 0 and 1 at F=127
    cyc(1'b0, 1'b1, 1'b1, 0, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 1, 8'hFF);
    run(16);

    // Noise voice
    cyc(1'b0, 1'b1, 1'b1, 3, 8'hFF);
    run(40);

    // Change F while running, then disable
    cyc(1'b0, 1'b1, 1'b1, 2, 8'h80);
    run(300);
    cyc(1'b0, 1'b1, 1'b1, 2, 8'h00);
    run(6);

    // Writes to unmapped addresses are ignored
    for (int a = 5; a < 8; a++) cyc(1'b0, 1'b1, 1'b1, a, 8'hFF);

    // Mid-tone reset
    cyc(1'b0, 1'b1, 1'b1, 2, 8'hFF);
    run(30);
    cyc(1'b1, 1'b1, 1'b1, 1, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 4, 8'h0F);
    for (int k = 0; k < NV; k++) cyc(1'b0, 1'b1, 1'b1, k, 8'hFF);
    run(60);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) wd = $urandom_range(0, 255);
      else wd = (($urandom_range(0, 5) != 0) ? 128 : 0) + $urandom_range(110, 127);
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 7), wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
